// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: aligns to Viterbi decoder latency against tx history and counts bit errors while locked
module viterbi_ber_checker #(
    parameter int MAX_LAT  = 32,
    parameter int CNT_W    = 16,
    parameter int SYNC_LEN = 16,
    parameter int WIN_LEN  = 32,
    parameter int LOSS_THR = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_bit_i,
    input  logic                       tx_valid_i,
    input  logic                       rx_bit_i,
    input  logic                       rx_valid_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] latency_o,
    output logic [CNT_W-1:0]           bit_ct_o,
    output logic [CNT_W-1:0]           err_ct_o,
    output logic                       sat_o
);
    localparam int LW = $clog2(MAX_LAT);
    localparam int WW = $clog2(WIN_LEN);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [MAX_LAT-1:0] hist_q, hist_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic [7:0]         run_q, run_d;
    logic [WW-1:0]      wpos_q, wpos_d;
    logic [8:0]         werr_q, werr_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               sat_q, sat_d;
    logic               locked_q, locked_d;
    logic               miss, wrap, bit_full, err_full;
    logic [8:0]         werr_n;

    // Next-state: history shift, latency search, locked counting, window loss detection, clear
    always_comb begin
        miss     = rx_bit_i ^ hist_q[lat_q];
        wrap     = wpos_q == WW'(WIN_LEN - 1);
        bit_full = &bit_q;
        err_full = &err_q;
        werr_n   = (wrap ? 9'd0 : werr_q) + 9'(miss);
        state_d  = state_q;
        hist_d   = tx_valid_i ? {hist_q[MAX_LAT-2:0], tx_bit_i} : hist_q;
        lat_d    = lat_q;
        run_d    = run_q;
        wpos_d   = wpos_q;
        werr_d   = werr_q;
        bit_d    = bit_q;
        err_d    = err_q;
        locked_d = locked_q;
        if (rx_valid_i) begin
            if (state_q == SEARCH) begin
                if (miss) begin
                    run_d = '0;
                    lat_d = lat_q + LW'(1);
                end else if (run_q == 8'(SYNC_LEN - 1)) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    run_d    = '0;
                    wpos_d   = '0;
                    werr_d   = '0;
                end else begin
                    run_d = run_q + 8'd1;
                end
            end else begin
                bit_d  = bit_full ? bit_q : bit_q + CNT_W'(1);
                err_d  = (miss && !bit_full && !err_full) ? err_q + CNT_W'(1) : err_q;
                wpos_d = wrap ? '0 : wpos_q + WW'(1);
                werr_d = werr_n;
                if (werr_n == 9'(LOSS_THR)) begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                    lat_d    = lat_q + LW'(1);
                    run_d    = '0;
                end
            end
        end
        sat_d = sat_q | (&bit_d) | (&err_d);
        if (clear_i) begin
            bit_d = '0;
            err_d = '0;
            sat_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SEARCH;
            hist_q   <= '0;
            lat_q    <= '0;
            run_q    <= '0;
            wpos_q   <= '0;
            werr_q   <= '0;
            bit_q    <= '0;
            err_q    <= '0;
            sat_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            lat_q    <= lat_d;
            run_q    <= run_d;
            wpos_q   <= wpos_d;
            werr_q   <= werr_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o  = locked_q;
    assign latency_o = lat_q;
    assign bit_ct_o  = bit_q;
    assign err_ct_o  = err_q;
    assign sat_o     = sat_q;
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker: scoreboard bench for viterbi_ber_checker (default and CNT_W=4 instances)
module tb_viterbi_ber_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_bit_i = 1'b0, tx_valid_i = 1'b0, rx_bit_i = 1'b0, rx_valid_i = 1'b0, clear_i = 1'b0;
    logic        locked0, sat0, locked4, sat4;
    logic [4:0]  lat0, lat4;
    logic [15:0] bct0, ect0;
    logic [3:0]  bct4, ect4;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = default instance, 1 = CNT_W=4 instance
    bit  lk[2];
    int  lat[2], run[2], wp[2], we[2], bc[2], ec[2];
    bit  sat[2];
    int  cmax[2] = '{65535, 15};
    bit  [31:0] mh;
    bit  [47:0] txh;
    bit  [14:0] lfsr = 15'h1ace;
    logic [38:0] q0[$], q1[$];
    int  wraps, prev_lat;
    bit  ever_lk;

    always #5 clk = ~clk;

    viterbi_ber_checker dut (
        .clk(clk), .rst(rst), .tx_bit_i(tx_bit_i), .tx_valid_i(tx_valid_i),
        .rx_bit_i(rx_bit_i), .rx_valid_i(rx_valid_i), .clear_i(clear_i),
        .locked_o(locked0), .latency_o(lat0), .bit_ct_o(bct0), .err_ct_o(ect0), .sat_o(sat0)
    );

    viterbi_ber_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .tx_bit_i(tx_bit_i), .tx_valid_i(tx_valid_i),
        .rx_bit_i(rx_bit_i), .rx_valid_i(rx_valid_i), .clear_i(clear_i),
        .locked_o(locked4), .latency_o(lat4), .bit_ct_o(bct4), .err_ct_o(ect4), .sat_o(sat4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [38:0] pk(input int i);
        return {lk[i], 5'(lat[i]), 16'(bc[i]), 16'(ec[i]), sat[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lk[i] = 0; lat[i] = 0; run[i] = 0; wp[i] = 0; we[i] = 0; bc[i] = 0; ec[i] = 0; sat[i] = 0;
        end
        mh = '0;
    endtask

    task automatic model_step(input bit txv, input bit txb, input bit rxv, input bit rxb, input bit clr);
        for (int i = 0; i < 2; i++) begin
            bit mm;
            int obc;
            mm = rxb != mh[lat[i]];
            if (rxv) begin
                if (!lk[i]) begin
                    if (mm) begin
                        run[i] = 0;
                        lat[i] = (lat[i] + 1) % 32;
                    end else begin
                        run[i]++;
                        if (run[i] == 16) begin
                            lk[i] = 1; run[i] = 0; wp[i] = 0; we[i] = 0;
                        end
                    end
                end else begin
                    obc = bc[i];
                    if (obc < cmax[i]) bc[i] = obc + 1;
                    if (mm && obc < cmax[i] && ec[i] < cmax[i]) ec[i]++;
                    if (wp[i] == 31) begin
                        wp[i] = 0; we[i] = 0;
                    end else wp[i]++;
                    if (mm) we[i]++;
                    if (we[i] == 8) begin
                        lk[i] = 0; lat[i] = (lat[i] + 1) % 32; run[i] = 0;
                    end
                    if (bc[i] == cmax[i] || ec[i] == cmax[i]) sat[i] = 1;
                end
            end
            if (clr) begin
                bc[i] = 0; ec[i] = 0; sat[i] = 0;
            end
        end
        if (txv) mh = {mh[30:0], txb};
    endtask

    task automatic cyc(input bit txv, input bit txb, input bit rxv, input bit rxb, input bit clr);
        tx_valid_i = txv; tx_bit_i = txb; rx_valid_i = rxv; rx_bit_i = rxb; clear_i = clr;
        model_step(txv, txb, rxv, rxb, clr);
        q0.push_back(pk(0));
        q1.push_back(pk(1));
        if (txv) txh = {txh[46:0], txb};
        @(posedge clk);
        #1;
        chk("cyc_def", {locked0, lat0, bct0, ect0, sat0}, q0.pop_front());
        chk("cyc_w4", {locked4, lat4, 12'd0, bct4, 12'd0, ect4, sat4}, q1.pop_front());
        if (prev_lat == 31 && lat0 == 5'd0) wraps++;
        prev_lat = int'(lat0);
        if (locked0) ever_lk = 1;
    endtask

    // rx mirrors tx history entry d (d tx samples behind the newest applied bit)
    task automatic step(input int d, input bit inv, input bit clr);
        bit b;
        b = lfsr[14] ^ lfsr[13];
        lfsr = {lfsr[13:0], b};
        cyc(1'b1, b, 1'b1, txh[d] ^ inv, clr);
    endtask

    task automatic fill();
        for (int i = 0; i < 40; i++) begin
            bit b;
            b = lfsr[14] ^ lfsr[13];
            lfsr = {lfsr[13:0], b};
            cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_lock(input int d);
        for (int i = 0; i < 2000 && !lk[0]; i++) step(d, 1'b0, 1'b0);
        chk("lock_reached", locked0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_def", {locked0, lat0, bct0, ect0, sat0}, 0);
        chk("rst_w4", {locked4, lat4, bct4, ect4, sat4}, 0);
        model_reset();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        txh = '0;
        prev_lat = 0;
        wraps = 0;
        ever_lk = 0;
        #2;
        chk("por_def", {locked0, lat0, bct0, ect0, sat0}, 0);
        chk("por_w4", {locked4, lat4, bct4, ect4, sat4}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill();
        wait_lock(9);
        chk("lat_lock9", lat0, 9);
        chk("bct_at_lock", bct0, 0);
        for (int j = 0; j < 1000; j++) step(9, 1'b0, 1'b0);
        chk("bct_1000", bct0, 1000);
        chk("ect_1000", ect0, 0);
        chk("bct4_sat", bct4, 15);
        chk("sat4_set", sat4, 1);
        step(9, 1'b0, 1'b1);
        chk("clr_bct4", bct4, 0);
        chk("clr_sat4", sat4, 0);
        chk("clr_bct", bct0, 0);
        for (int j = 0; j < 320; j++) step(9, (j % 32) == 31, 1'b0);
        chk("ect_320", ect0, 10);
        chk("bct_320", bct0, 320);
        chk("lock_kept", locked0, 1);
        for (int j = 0; j < 32; j++) step(9, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) step(9, 1'b1, 1'b0);
        chk("lock_7err", locked0, 1);
        step(9, 1'b1, 1'b0);
        chk("loss_8err", locked0, 0);
        chk("loss_lat10", lat0, 10);
        chk("loss_ect", ect0, 18);
        wraps = 0;
        wait_lock(9);
        chk("relock_lat9", lat0, 9);
        chk("relock_wrap", wraps, 1);
        do_reset();
        @(posedge clk);
        #1;
        fill();
        wait_lock(31);
        chk("lat_lock31", lat0, 31);
        do_reset();
        @(posedge clk);
        #1;
        fill();
        ever_lk = 0;
        wraps = 0;
        prev_lat = 0;
        for (int j = 0; j < 600; j++) step(40, 1'b0, 1'b0);
        chk("d40_nolock", ever_lk, 0);
        chk("d40_wraps", wraps >= 2, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
